// File: rtl/fnd_scan_driver_if.sv
// FND scan driver bus: time selector values in, common-anode FND pins out.
interface fnd_scan_driver_if;
    logic [6:0] digit_h;
    logic [6:0] digit_l;
    logic       dot;
    logic [3:0] fnd_com;
    logic [7:0] fnd_font;

    modport master (
        output digit_h, digit_l, dot,
        input  fnd_com, fnd_font
    );

    modport slave (
        input  digit_h, digit_l, dot,
        output fnd_com, fnd_font
    );
endinterface

// File: rtl/fnd_scan_driver.sv
// 4-digit multiplexed FND driver for two 0..99 values plus a decimal point.
// Optional FND_LEADING_ZERO_BLANK_EN blanks a zero tens digit of the h pair.
module fnd_scan_driver #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic                clk,
    input  logic                reset,
    fnd_scan_driver_if.slave    bus
);
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] psc_q, psc_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    h_q, h_d, l_q, l_d;
    logic          dot_q, dot_d;
    logic [3:0]    com_q, com_d;
    logic [7:0]    font_q, font_d;

    logic          tick, cap;
    logic [6:0]    h_src, l_src;
    logic          dot_src;
    logic [3:0]    h_t, h_o, l_t, l_o, num;

    function automatic logic [6:0] clamp99(input logic [6:0] v);
        clamp99 = (v >= 7'd100) ? 7'd99 : v;
    endfunction

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        tens_of = 4'd0;
        for (int k = 1; k < 10; k++)
            if (v >= 7'(10 * k))
                tens_of = 4'(k);
    endfunction

    function automatic logic [3:0] ones_of(input logic [6:0] v, input logic [3:0] t);
        ones_of = 4'(v - 7'(t) * 7'd10);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        unique case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
        tick  = (psc_q == CW'(DIV - 1));
        psc_d = tick ? '0 : psc_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;
        cap   = tick && (idx_d == 2'd0);

        // Digit 0 renders from the values captured on the same edge.
        h_src   = cap ? bus.digit_h : h_q;
        l_src   = cap ? bus.digit_l : l_q;
        dot_src = cap ? bus.dot     : dot_q;
        h_d     = h_src;
        l_d     = l_src;
        dot_d   = dot_src;

        h_t = tens_of(clamp99(h_src));
        h_o = ones_of(clamp99(h_src), h_t);
        l_t = tens_of(clamp99(l_src));
        l_o = ones_of(clamp99(l_src), l_t);

        unique case (idx_d)
            2'd0:    num = l_o;
            2'd1:    num = l_t;
            2'd2:    num = h_o;
            default: num = h_t;
        endcase

        com_d  = ~(4'b0001 << idx_d);
        font_d = {~((idx_d == 2'd2) && dot_src), seg7(num)};
`ifdef FND_LEADING_ZERO_BLANK_EN
        if ((idx_d == 2'd3) && (h_t == 4'd0))
            font_d = 8'hFF;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q  <= '0;
            idx_q  <= 2'd3;
            h_q    <= '0;
            l_q    <= '0;
            dot_q  <= 1'b0;
            com_q  <= 4'b1111;
            font_q <= 8'hFF;
        end else begin
            psc_q <= psc_d;
            idx_q <= idx_d;
            h_q   <= h_d;
            l_q   <= l_d;
            dot_q <= dot_d;
            if (tick) begin
                com_q  <= com_d;
                font_q <= font_d;
            end
        end
    end

    assign bus.fnd_com  = com_q;
    assign bus.fnd_font = font_q;
endmodule
